cnt_ctx_arbiter: RTL and testbench
==================================

# cnt_ctx_arbiter

Scheduler that shares one external dual-context step counter between two requesters. Each requester owns one counter context. The block clears the counter at job start, arbitrates per-cycle step requests, and drives the counter's enable/clear/select controls. It counts context wrap-arounds ("passes") so it can report per-context completion and job completion. It sits between the two address-generation clients and the dual-context counter in the feeder datapath.

## Interface
Parameters:
- CNT_W, 8, width of the counter value returned to clients
- PASS_W, 8, width of the per-context pass limit and pass counters

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous reset, active-high
- i_start  in  1  job start pulse; accepted only in IDLE
- i_passes0  in  PASS_W  wrap count for context 0; sampled on accepted i_start; 0 = context disabled
- i_passes1  in  PASS_W  wrap count for context 1; same rules as i_passes0
- i_req0  in  1  context-0 step request, level
- i_req1  in  1  context-1 step request, level
- o_gnt0  out  1  context-0 step granted this cycle
- o_gnt1  out  1  context-1 step granted this cycle
- o_cnt  out  CNT_W  counter value (pre-step) for the granted context; valid with o_gnt*
- o_last  out  1  granted step completed that context's final pass; valid with o_gnt*
- o_ctr_en  out  1  counter enable
- o_ctr_clear  out  1  counter clear (both contexts)
- o_ctr_sel  out  1  counter context select (1 = context 0, 0 = context 1)
- i_ctr_flag  in  1  counter overflow flag for the selected context
- i_ctr_cnt  in  CNT_W  counter value for the selected context
- o_busy  out  1  job in progress (CLEAR or RUN)
- o_done0  out  1  context 0 finished; level, cleared on next accepted i_start
- o_done1  out  1  context 1 finished; same rules as o_done0
- o_done  out  1  one-cycle job-complete pulse

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE: if i_start, latch i_passes0/1, zero both pass counters, clear o_done0/1, go to CLEAR.
- CLEAR: assert o_ctr_clear for one cycle; no grants.
  - Set o_doneN = 1 for each context whose latched passes value is 0.
  - Go to DONE if both contexts are done, else go to RUN.
- RUN: grant at most one requester per cycle, among contexts that have requested and are not done.
  - On a grant to context c:
    - Drive o_ctr_sel to context c, assert o_ctr_en, and pulse o_gntc.
    - o_cnt = i_ctr_cnt.
  - If i_ctr_flag on a grant: increment pass_cnt[c]. If the new value equals passes[c], set o_donec and assert o_last.
  - When both done flags are set, go to DONE the following cycle.
- DONE: o_done = 1 for one cycle, then go to IDLE.
- i_start outside IDLE is ignored.
- Requests from a done or disabled context are ignored.
- Arbitration is round-robin via a last-grant pointer, reset to context 1 so that context 0 wins the first contention.
  - With a single eligible requester, that requester is granted every cycle.
- When no grant is issued, o_ctr_sel holds its previous value. Select changes only on a grant cycle.
- Pass counters are PASS_W wide and never wrap: the done flag stops further grants for that context.

## Timing
- Grant is same-cycle (Mealy): o_gnt*, o_ctr_en, o_ctr_sel, o_cnt and o_last are combinational from the requests, the current state and the counter inputs.
- The counter advances at the next clock edge. The next grant to the same context sees the updated value.
- Counter select and flag are combinational in the counter, so a single grant costs one cycle.
- Latency: i_start → o_ctr_clear, 1 cycle. Final o_last → o_done, 2 cycles (RUN→DONE transition, then DONE pulse).
- Reset value of every output is 0, and the state is IDLE. o_ctr_sel resets to 0.
- Reset mid-job: returns to IDLE immediately and discards the pass state. The external counter is not cleared by reset; the next job's CLEAR handles it.
- Simultaneous final steps: only one grant per cycle, so the second context completes on a later grant.

## Configuration
- CNT_CTX_ARB_RR_EN defined: round-robin arbitration as described above.
- CNT_CTX_ARB_RR_EN undefined: fixed priority, context 0 always wins. The last-grant pointer is not implemented. All other behaviour is identical.

## Test plan
- Reset, then idle: all outputs 0. i_req0 = i_req1 = 1 with no start → no grants.
- passes0 = 2, passes1 = 0, counter lim = 4, step = 1, i_req0 held:
  - o_done1 = 1 after CLEAR.
  - 8 consecutive grants to context 0.
  - o_last on the 8th grant.
  - o_done pulse 2 cycles after the 8th grant.
- passes0 = passes1 = 1, lim = 3, both requests held, RR build:
  - Grants alternate 0,1,0,1,0,1.
  - o_last on grants 5 and 6.
  - Fixed-priority build: three grants to context 0, then three to context 1.
- passes0 = passes1 = 0: CLEAR then DONE. o_done pulses 2 cycles after i_start, with no grants.
- i_rst asserted mid-RUN after 3 grants, then new i_start with passes0 = 1, lim = 2: o_ctr_clear pulses, o_cnt returns 0 then 1, o_last on the 2nd grant.
- i_start pulsed during RUN: ignored. Latched passes are unchanged and done timing matches the run without the extra pulse.

Source files
------------

// File: rtl/cnt_ctx_arbiter_if.sv
// Client/counter-side signal bundle for cnt_ctx_arbiter.
// Latency: none (wires only).
// Backpressure: none; the slave modport is the arbiter's view, the master modport is the environment's.
interface cnt_ctx_arbiter_if #(
    parameter int CNT_W  = 8,
    parameter int PASS_W = 8
);
    logic              i_start;
    logic [PASS_W-1:0] i_passes0;
    logic [PASS_W-1:0] i_passes1;
    logic              i_req0;
    logic              i_req1;
    logic              o_gnt0;
    logic              o_gnt1;
    logic [CNT_W-1:0]  o_cnt;
    logic              o_last;
    logic              o_ctr_en;
    logic              o_ctr_clear;
    logic              o_ctr_sel;
    logic              i_ctr_flag;
    logic [CNT_W-1:0]  i_ctr_cnt;
    logic              o_busy;
    logic              o_done0;
    logic              o_done1;
    logic              o_done;

    modport slave (
        input  i_start, i_passes0, i_passes1, i_req0, i_req1, i_ctr_flag, i_ctr_cnt,
        output o_gnt0, o_gnt1, o_cnt, o_last, o_ctr_en, o_ctr_clear, o_ctr_sel,
               o_busy, o_done0, o_done1, o_done
    );

    modport master (
        output i_start, i_passes0, i_passes1, i_req0, i_req1, i_ctr_flag, i_ctr_cnt,
        input  o_gnt0, o_gnt1, o_cnt, o_last, o_ctr_en, o_ctr_clear, o_ctr_sel,
               o_busy, o_done0, o_done1, o_done
    );
endinterface

// File: rtl/cnt_ctx_arbiter.sv
// Shares one dual-context step counter between two requesters; counts context wraps to report completion.
// Latency: grants are same-cycle (Mealy); i_start->o_ctr_clear 1 cycle; final o_last->o_done 2 cycles.
// Backpressure: level requests simply wait until granted; one step per cycle. CNT_CTX_ARB_RR_EN selects round-robin.
module cnt_ctx_arbiter #(
    parameter int CNT_W  = 8,
    parameter int PASS_W = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    cnt_ctx_arbiter_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [1:0][PASS_W-1:0]  passes_q, passes_d;
    logic [1:0][PASS_W-1:0]  pass_cnt_q, pass_cnt_d;
    logic [1:0]              done_q, done_d;
    logic                    sel_q, sel_d;

    logic [1:0]              req;
    logic [1:0]              elig;
    logic [1:0]              gnt;
    logic                    gidx;
    logic [PASS_W-1:0]       pass_inc;
    logic                    last;
    logic [CNT_W-1:0]        cnt_val;

    // Only unfinished contexts compete, and only while running.
    assign req  = {bus.i_req1, bus.i_req0};
    assign elig = (state_q == ST_RUN) ? (req & ~done_q) : 2'b00;
    assign gidx = gnt[1];

`ifdef CNT_CTX_ARB_RR_EN
    logic last_gnt_q, last_gnt_d;

    // Last-grant pointer starts at context 1 so context 0 wins the first contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_gnt_q <= 1'b1;
        end else begin
            last_gnt_q <= last_gnt_d;
        end
    end

    // Round-robin pick: on contention, the context not granted last time wins.
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (elig == 2'b11) begin
            gnt = last_gnt_q ? 2'b01 : 2'b10;
        end else begin
            gnt = elig;
        end
        if (|gnt) begin
            last_gnt_d = gnt[1];
        end
    end
`else
    // Fixed priority pick: context 0 always wins contention.
    always_comb begin
        gnt = elig[0] ? 2'b01 : elig;
    end
`endif

    // Next-state logic: job sequencing, pass counting and counter select tracking.
    always_comb begin
        state_d    = state_q;
        passes_d   = passes_q;
        pass_cnt_d = pass_cnt_q;
        done_d     = done_q;
        sel_d      = sel_q;
        pass_inc   = pass_cnt_q[gidx] + PASS_W'(1);
        last       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    passes_d   = {bus.i_passes1, bus.i_passes0};
                    pass_cnt_d = '0;
                    done_d     = 2'b00;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                // A zero pass limit means the context has nothing to do.
                done_d[0] = (passes_q[0] == '0);
                done_d[1] = (passes_q[1] == '0);
                state_d   = ((passes_q[0] == '0) && (passes_q[1] == '0)) ? ST_DONE : ST_RUN;
            end
            ST_RUN: begin
                // Registered done flags: the transition happens the cycle after the final step.
                if (&done_q) begin
                    state_d = ST_DONE;
                end
                if (|gnt) begin
                    sel_d = ~gidx;
                    if (bus.i_ctr_flag) begin
                        pass_cnt_d[gidx] = pass_inc;
                        if (pass_inc == passes_q[gidx]) begin
                            done_d[gidx] = 1'b1;
                            last         = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers; reset abandons any job but leaves the external counter alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            passes_q   <= '0;
            pass_cnt_q <= '0;
            done_q     <= 2'b00;
            sel_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            passes_q   <= passes_d;
            pass_cnt_q <= pass_cnt_d;
            done_q     <= done_d;
            sel_q      <= sel_d;
        end
    end

    assign cnt_val         = (|gnt) ? bus.i_ctr_cnt : '0;

    assign bus.o_gnt0      = gnt[0];
    assign bus.o_gnt1      = gnt[1];
    assign bus.o_cnt       = cnt_val;
    assign bus.o_last      = last;
    assign bus.o_ctr_en    = |gnt;
    assign bus.o_ctr_clear = (state_q == ST_CLEAR);
    assign bus.o_ctr_sel   = sel_d;
    assign bus.o_busy      = (state_q == ST_CLEAR) || (state_q == ST_RUN);
    assign bus.o_done0     = done_q[0];
    assign bus.o_done1     = done_q[1];
    assign bus.o_done      = (state_q == ST_DONE);

endmodule

// File: tb/tb_cnt_ctx_arbiter.sv
// Randomized and directed bench for cnt_ctx_arbiter against a behavioural job/arbitration model.
// Includes a dual-context step counter (step 1, wraps at lim) driven by the arbiter's controls.
// Arbitration expectations follow CNT_CTX_ARB_RR_EN like the design.
module tb_cnt_ctx_arbiter;
    localparam int CNT_W  = 8;
    localparam int PASS_W = 8;
`ifdef CNT_CTX_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    localparam int P_IDLE = 0, P_CLEAR = 1, P_RUN = 2, P_DONE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cnt_ctx_arbiter_if #(.CNT_W(CNT_W), .PASS_W(PASS_W)) ifc ();

    cnt_ctx_arbiter #(.CNT_W(CNT_W), .PASS_W(PASS_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (ifc)
    );

    // External counter: per-context value, wraps to 0 after reaching lim-1.
    int ctr [2];
    int lim;
    assign ifc.i_ctr_cnt  = CNT_W'(ctr[ifc.o_ctr_sel ? 0 : 1]);
    assign ifc.i_ctr_flag = (ctr[ifc.o_ctr_sel ? 0 : 1] + 1 >= lim);

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    // Reference model state.
    int m_phase;
    int m_pass [2];
    int m_wraps [2];
    bit m_fin [2];
    int m_prev;
    int m_sel;
    int e_w;
    bit e_wrap, e_last;

    // Observation logs.
    int gnt_log [$];
    int cnt_log [$];
    int last_log [$];
    int cyc = 0, start_cyc, last_gnt_cyc, done_cyc, n_clear;
    bit done_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int qget(input int q [$], input int i);
        return (q.size() > i) ? q[i] : -1;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_fin   = '{0, 0};
        m_wraps = '{0, 0};
        m_prev  = 1;
        m_sel   = 1;
    endtask

    // Decide this cycle's winner from the job rules.
    task automatic model_expect();
        bit c0, c1;
        e_w = -1; e_wrap = 0; e_last = 0;
        if (m_phase == P_RUN && !(m_fin[0] && m_fin[1])) begin
            c0 = ifc.i_req0 && !m_fin[0];
            c1 = ifc.i_req1 && !m_fin[1];
            if (c0 && c1)  e_w = RR ? 1 - m_prev : 0;
            else if (c0)   e_w = 0;
            else if (c1)   e_w = 1;
        end
        if (e_w >= 0) begin
            e_wrap = (ctr[e_w] + 1 >= lim);
            e_last = e_wrap && (m_wraps[e_w] + 1 == m_pass[e_w]);
        end
    endtask

    task automatic model_update(input bit r, input bit st, input int p0, input int p1);
        if (r) begin
            model_reset();
            return;
        end
        case (m_phase)
            P_IDLE: if (st) begin
                m_pass  = '{p0, p1};
                m_wraps = '{0, 0};
                m_fin   = '{0, 0};
                m_phase = P_CLEAR;
            end
            P_CLEAR: begin
                m_fin[0] = (m_pass[0] == 0);
                m_fin[1] = (m_pass[1] == 0);
                m_phase  = (m_fin[0] && m_fin[1]) ? P_DONE : P_RUN;
            end
            P_RUN: begin
                if (m_fin[0] && m_fin[1]) begin
                    m_phase = P_DONE;
                end else if (e_w >= 0) begin
                    m_prev = e_w;
                    m_sel  = e_w;
                    if (e_wrap) begin
                        m_wraps[e_w]++;
                        if (m_wraps[e_w] == m_pass[e_w]) m_fin[e_w] = 1;
                    end
                end
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    function automatic logic [9:0] outs();
        return {ifc.o_gnt1, ifc.o_gnt0, ifc.o_ctr_en, ifc.o_ctr_clear, ifc.o_ctr_sel,
                ifc.o_last, ifc.o_busy, ifc.o_done0, ifc.o_done1, ifc.o_done};
    endfunction

    // One clock: check at negedge, then advance counter and model just after posedge.
    task automatic step();
        logic [9:0] ev;
        bit s_clr, s_en, s_sel, s_flag;
        @(negedge clk);
        model_expect();
        ev = {e_w == 1, e_w == 0, e_w >= 0, m_phase == P_CLEAR,
              (e_w >= 0) ? (e_w == 0) : (m_sel == 0), e_last,
              m_phase == P_CLEAR || m_phase == P_RUN, m_fin[0], m_fin[1], m_phase == P_DONE};
        if (chk_en) begin
            check("ctl", 32'(outs()), 32'(ev));
            check("cnt", 32'(ifc.o_cnt), (e_w >= 0) ? ctr[e_w] : 0);
        end
        if (ifc.o_gnt0 || ifc.o_gnt1) begin
            gnt_log.push_back(int'(ifc.o_gnt1));
            cnt_log.push_back(int'(ifc.o_cnt));
            if (ifc.o_last) last_log.push_back(gnt_log.size());
            last_gnt_cyc = cyc;
        end
        if (ifc.o_ctr_clear) n_clear++;
        if (ifc.o_done) begin
            done_seen = 1;
            done_cyc  = cyc;
        end
        s_clr = ifc.o_ctr_clear; s_en = ifc.o_ctr_en; s_sel = ifc.o_ctr_sel; s_flag = ifc.i_ctr_flag;
        @(posedge clk);
        #1;
        if (s_clr) begin
            ctr = '{0, 0};
        end else if (s_en) begin
            ctr[s_sel ? 0 : 1] = s_flag ? 0 : ctr[s_sel ? 0 : 1] + 1;
        end
        model_update(rst, ifc.i_start, int'(ifc.i_passes0), int'(ifc.i_passes1));
        cyc++;
    endtask

    task automatic clear_logs();
        gnt_log.delete(); cnt_log.delete(); last_log.delete();
        done_seen = 0; n_clear = 0; done_cyc = -1; last_gnt_cyc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Start a job and run until o_done or the budget runs out; poke >= 0 injects a stray start.
    task automatic run_job(input int p0, input int p1, input int l, input bit r0, input bit r1,
                           input bit rnd, input int poke, input int budget);
        lim = l;
        clear_logs();
        ifc.i_passes0 = PASS_W'(p0);
        ifc.i_passes1 = PASS_W'(p1);
        ifc.i_req0 = r0;
        ifc.i_req1 = r1;
        ifc.i_start = 1'b1;
        start_cyc = cyc;
        step();
        ifc.i_start = 1'b0;
        for (int k = 0; k < budget && !done_seen; k++) begin
            ifc.i_start = (k == poke);
            if (k == poke) begin
                ifc.i_passes0 = 8'd7;
                ifc.i_passes1 = 8'd7;
            end
            if (rnd) begin
                ifc.i_req0    = 1'($urandom_range(0, 1));
                ifc.i_req1    = 1'($urandom_range(0, 1));
                ifc.i_start   = ($urandom_range(0, 7) == 0);
                ifc.i_passes0 = PASS_W'($urandom_range(0, 3));
                ifc.i_passes1 = PASS_W'($urandom_range(0, 3));
            end
            step();
        end
        ifc.i_start = 1'b0;
        check("job_timeout", 32'(done_seen), 32'd1);
    endtask

    initial begin
        int exp_seq [6];
        int exp_last [2];
        ifc.i_start = 0; ifc.i_passes0 = 0; ifc.i_passes1 = 0; ifc.i_req0 = 0; ifc.i_req1 = 0;
        ctr = '{0, 0};
        lim = 4;
        model_reset();
        clear_logs();

        // Reset and idle behaviour.
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        check("rst_outs", 32'(outs()), 32'd0);
        check("rst_cnt", 32'(ifc.o_cnt), 32'd0);
        ifc.i_req0 = 1; ifc.i_req1 = 1;
        repeat (3) step();
        check("idle_no_gnt", gnt_log.size(), 0);

        // Context 0 alone: 2 passes of 4 steps, context 1 disabled.
        do_reset();
        lim = 4;
        ifc.i_passes0 = 2; ifc.i_passes1 = 0; ifc.i_req0 = 1; ifc.i_req1 = 0;
        ifc.i_start = 1; start_cyc = cyc; clear_logs();
        step();
        ifc.i_start = 0;
        step();
        check("a_done1_after_clear", 32'(ifc.o_done1), 32'd1);
        for (int k = 0; k < 30 && !done_seen; k++) step();
        check("a_timeout", 32'(done_seen), 32'd1);
        check("a_ngnt", gnt_log.size(), 8);
        check("a_all_ctx0", gnt_log.sum(), 0);
        check("a_last_idx", qget(last_log, 0), 8);
        check("a_nlast", last_log.size(), 1);
        check("a_done_lat", done_cyc - last_gnt_cyc, 2);

        // Both contexts contend: 1 pass of 3 steps each.
        do_reset();
        run_job(1, 1, 3, 1, 1, 0, -1, 40);
        if (RR) begin
            exp_seq = '{0, 1, 0, 1, 0, 1};
            exp_last = '{5, 6};
        end else begin
            exp_seq = '{0, 0, 0, 1, 1, 1};
            exp_last = '{3, 6};
        end
        check("b_ngnt", gnt_log.size(), 6);
        for (int i = 0; i < 6; i++) check("b_seq", qget(gnt_log, i), exp_seq[i]);
        check("b_last0", qget(last_log, 0), exp_last[0]);
        check("b_last1", qget(last_log, 1), exp_last[1]);

        // Both disabled: CLEAR then DONE.
        run_job(0, 0, 3, 1, 1, 0, -1, 10);
        check("c_done_lat", done_cyc - start_cyc, 2);
        check("c_ngnt", gnt_log.size(), 0);
        check("c_nclear", n_clear, 1);

        // Reset in the middle of a job, then a fresh short job.
        lim = 4;
        ifc.i_passes0 = 5; ifc.i_passes1 = 0; ifc.i_req0 = 1; ifc.i_req1 = 0;
        ifc.i_start = 1; clear_logs();
        step();
        ifc.i_start = 0;
        for (int k = 0; k < 10 && gnt_log.size() < 3; k++) step();
        check("d_pre_ngnt", gnt_log.size(), 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("d_busy_after_rst", 32'(ifc.o_busy), 32'd0);
        run_job(1, 0, 2, 1, 0, 0, -1, 20);
        check("d_nclear", n_clear, 1);
        check("d_cnt0", qget(cnt_log, 0), 0);
        check("d_cnt1", qget(cnt_log, 1), 1);
        check("d_last_idx", qget(last_log, 0), 2);

        // Stray start during RUN must not reload pass limits.
        run_job(2, 0, 3, 1, 0, 0, 3, 40);
        check("e_ngnt", gnt_log.size(), 6);
        check("e_done_lat", done_cyc - start_cyc, 9);

        // Randomized jobs.
        for (int j = 0; j < 40; j++) begin
            if ($urandom_range(0, 3) == 0) do_reset();
            run_job($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 5),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1, -1, 300);
            ifc.i_req0 = 1'($urandom_range(0, 1));
            ifc.i_req1 = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
